// File: rtl/fp_mac_pkg.sv
// fp_mac_pkg: shared state encoding, width helpers and round/saturate quantizer for the fixed-point MAC.
package fp_mac_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUTPUT} state_t;
  localparam int QW = 128;
  typedef struct packed {
    logic signed [QW-1:0] val;
    logic sat;
  } q_t;
  function automatic int acc_width(input int in_w, input int lanes, input int beats_max);
    return 2*in_w + $clog2(lanes*beats_max);
  endfunction
  function automatic int beat_cnt_width(input int beats_max);
    return $clog2(beats_max+1);
  endfunction
  // Round half up, arithmetic shift, then clip to the signed or unsigned output range.
  function automatic q_t quantize(input logic signed [QW-1:0] v, input int sh, input int out_w, input bit sgn);
    logic signed [QW-1:0] one, r, hi, lo;
    q_t q;
    one = 1;
    r = (v + ((one <<< sh) >>> 1)) >>> sh;
    hi = sgn ? (one <<< (out_w-1)) - one : (one <<< out_w) - one;
    lo = '0;
    if (sgn) lo = -(one <<< (out_w-1));
    q.sat = (r > hi) || (r < lo);
    q.val = (r > hi) ? hi : (r < lo) ? lo : r;
    return q;
  endfunction
endpackage

// File: rtl/fp_mac_quant.sv
// fp_mac_quant: combinational round, shift and saturate of a wide accumulator to the output format.
module fp_mac_quant
  import fp_mac_pkg::*;
#(
  parameter int ACC_W = 38,
  parameter int SH = 8,
  parameter int OUT_W = 16,
  parameter int SIGNED = 1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);
  logic signed [QW-1:0] v;
  q_t q;
  logic unused_hi;
  assign v = {{(QW-ACC_W){(SIGNED != 0) && acc[ACC_W-1]}}, acc};
  assign q = quantize(v, SH, OUT_W, SIGNED != 0);
  assign data = q.val[OUT_W-1:0];
  assign sat = q.sat;
  assign unused_hi = ^q.val[QW-1:OUT_W];
endmodule

// File: rtl/fp_mac_stream.sv
// fp_mac_stream: pipelined streaming fixed-point dot product with configurable beat count and
// a rounded, saturated valid/ready result.
module fp_mac_stream
  import fp_mac_pkg::*;
#(
  parameter int IN_INT_W = 8,
  parameter int IN_FRAC_W = 8,
  parameter int OUT_INT_W = 8,
  parameter int OUT_FRAC_W = 8,
  parameter int LANES = 4,
  parameter int BEATS_MAX = 16,
  parameter int SIGNED = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [$clog2(BEATS_MAX+1)-1:0]            cfg_beats,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]     in_a,
  input  logic [LANES*(IN_INT_W+IN_FRAC_W)-1:0]     in_b,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUT_INT_W+OUT_FRAC_W-1:0]           out_data,
  output logic                                      out_sat
);
  localparam int IN_W = IN_INT_W + IN_FRAC_W;
  localparam int PW = 2*IN_W;
  localparam int OUT_W = OUT_INT_W + OUT_FRAC_W;
  localparam int ACC_W = acc_width(IN_W, LANES, BEATS_MAX);
  localparam int CW = beat_cnt_width(BEATS_MAX);
  localparam int SH = 2*IN_FRAC_W - OUT_FRAC_W;
  state_t state, state_n;
  logic [CW-1:0] cnt, beats_n, eff;
  logic [PW-1:0] prod [LANES];
  logic [PW-1:0] s1_prod [LANES];
  logic s1_v, accept, q_sat;
  logic [ACC_W-1:0] acc, lane_sum;
  logic [OUT_W-1:0] q_data;
  assign in_ready = !rst && (state == IDLE || state == ACCUM);
  assign out_valid = state == OUTPUT;
  assign accept = in_valid && in_ready;
  assign eff = (cfg_beats == '0) ? CW'(1) : (cfg_beats > CW'(BEATS_MAX)) ? CW'(BEATS_MAX) : cfg_beats;
  // Operands are extended to full product width so a plain multiply yields the exact product.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PW-1:0] ax, bx;
    assign ax = {{IN_W{(SIGNED != 0) && in_a[i*IN_W+IN_W-1]}}, in_a[i*IN_W +: IN_W]};
    assign bx = {{IN_W{(SIGNED != 0) && in_b[i*IN_W+IN_W-1]}}, in_b[i*IN_W +: IN_W]};
    assign prod[i] = ax * bx;
  end
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++)
      lane_sum = lane_sum + {{(ACC_W-PW){(SIGNED != 0) && s1_prod[i][PW-1]}}, s1_prod[i]};
  end
  always_ff @(posedge clk) if (accept) s1_prod <= prod;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      acc <= '0;
    end else begin
      s1_v <= accept;
      acc <= (state == OUTPUT && out_ready) ? '0 : s1_v ? acc + lane_sum : acc;
    end
  end
  fp_mac_quant #(.ACC_W(ACC_W), .SH(SH), .OUT_W(OUT_W), .SIGNED(SIGNED)) u_quant (
    .acc(acc), .data(q_data), .sat(q_sat)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = (eff == CW'(1)) ? DRAIN : ACCUM;
      ACCUM:   if (accept && cnt == beats_n - CW'(1)) state_n = DRAIN;
      DRAIN:   if (!s1_v) state_n = OUTPUT;
      OUTPUT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beats_n <= '0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) cnt <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
      if (accept && state == IDLE) beats_n <= eff;
      if (state == DRAIN && !s1_v) begin
        out_data <= q_data;
        out_sat <= q_sat;
      end
    end
  end
endmodule

// File: tb/tb_fp_mac_stream.sv
// tb_fp_mac_stream: table vectors, hand-written corner sequences and random vectors against an integer reference.
module tb_fp_mac_stream;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] cfg_beats;
  logic in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [63:0] in_a, in_b;
  logic [15:0] out_data;
  int tests = 0, fails = 0;
  logic [63:0] ba [32];
  logic [63:0] bb [32];
  typedef struct {
    int cfg;
    logic [63:0] a, b;
    int gap, bp;
    logic [15:0] d;
    logic s;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  fp_mac_stream dut (
    .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  task automatic chk(input string n, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  function automatic int eff(input int c);
    return c == 0 ? 1 : c > 16 ? 16 : c;
  endfunction

  function automatic void model(input int n, output logic [15:0] d, output logic s);
    longint sum, q;
    sum = 0;
    for (int k = 0; k < n; k++)
      for (int l = 0; l < 4; l++)
        sum += longint'($signed(ba[k][l*16 +: 16])) * longint'($signed(bb[k][l*16 +: 16]));
    q = (sum + 128) >>> 8;
    s = q > 32767 || q < -32768;
    q = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
    d = q[15:0];
  endfunction

  function automatic logic [63:0] rep(input logic [15:0] v);
    return {4{v}};
  endfunction

  task automatic fill(input logic [63:0] a, input logic [63:0] b);
    for (int k = 0; k < 32; k++) begin
      ba[k] = a;
      bb[k] = b;
    end
  endtask

  task automatic run_vec(input string n, input int cfg, input int gap, input int bp,
                         input logic [15:0] ed, input logic es);
    int acc_n, cyc, last, lat;
    logic [15:0] hd;
    logic hs;
    bit ok;
    acc_n = 0; cyc = 0; last = 0; lat = -1;
    cfg_beats = 5'(cfg);
    while (lat < 0 && cyc < 300) begin
      in_valid = (gap == 0 || cyc % (gap + 1) == 0) && acc_n < 32;
      in_a = in_valid ? ba[acc_n] : {$urandom, $urandom};
      in_b = in_valid ? bb[acc_n] : {$urandom, $urandom};
      @(negedge clk);
      if (out_valid) lat = cyc - last;
      else if (in_valid && in_ready) begin
        acc_n++;
        last = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({n, " latency"}, lat, 3);
    chk({n, " beats"}, acc_n, eff(cfg));
    chk({n, " data"}, out_data, ed);
    chk({n, " sat"}, out_sat, es);
    hd = out_data; hs = out_sat; ok = 1'b1;
    repeat (bp) begin
      @(posedge clk);
      #1;
      in_a = {$urandom, $urandom};
      cfg_beats = 5'($urandom);
      if (out_data !== hd || out_sat !== hs || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    if (bp > 0) chk({n, " hold"}, ok, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({n, " valid drop"}, out_valid, 0);
    chk({n, " ready back"}, in_ready, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic s;
    bit ok;
    int cfg;
    vt[0] = '{1,  rep(16'h0100), rep(16'h0200), 0, 5, 16'h0800, 1'b0};
    vt[1] = '{3,  rep(16'hFE80), rep(16'h0200), 1, 0, 16'hDC00, 1'b0};
    vt[2] = '{1,  rep(16'h7F00), rep(16'h7F00), 0, 0, 16'h7FFF, 1'b1};
    vt[3] = '{1,  rep(16'h8100), rep(16'h7F00), 0, 0, 16'h8000, 1'b1};
    vt[4] = '{1,  64'h1, 64'h0080, 0, 0, 16'h0001, 1'b0};
    vt[5] = '{1,  64'h1, 64'h007F, 0, 0, 16'h0000, 1'b0};
    vt[6] = '{0,  rep(16'h0100), rep(16'h0200), 0, 0, 16'h0800, 1'b0};
    vt[7] = '{31, rep(16'h0100), rep(16'h0010), 0, 2, 16'h0400, 1'b0};
    in_valid = 1'b0; out_ready = 1'b0; cfg_beats = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    chk("release in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      fill(vt[i].a, vt[i].b);
      run_vec($sformatf("vec%0d", i), vt[i].cfg, vt[i].gap, vt[i].bp, vt[i].d, vt[i].s);
    end
    fill(rep(16'h0100), rep(16'h0200));
    cfg_beats = 5'd4;
    in_valid = 1'b1; in_a = ba[0]; in_b = bb[0];
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("midreset no output", ok, 1);
    @(posedge clk);
    #1;
    run_vec("after reset", 1, 0, 0, 16'h0800, 1'b0);
    for (int it = 0; it < 24; it++) begin
      cfg = $urandom_range(0, 20);
      for (int k = 0; k < 32; k++)
        for (int l = 0; l < 4; l++) begin
          ba[k][l*16 +: 16] = (it % 2 == 0) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
          bb[k][l*16 +: 16] = (it % 2 == 0) ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
        end
      model(eff(cfg), d, s);
      run_vec($sformatf("rand%0d", it), cfg, $urandom_range(0, 2), $urandom_range(0, 2), d, s);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
